// File: rtl/microbot_motor_driver.sv
// Dual H-bridge PWM driver: soft-start duty ramp, dead time on every direction change
// and sticky illegal-command fault. Define MOTOR_BRAKE_EN for a brake stop level; default coasts.
module microbot_motor_driver #(
    parameter int CNT_W       = 8,
    parameter int DEAD_CYCLES = 16,
    parameter int RAMP_STEP   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_a_fwd,
    input  logic             cmd_a_rev,
    input  logic             cmd_b_fwd,
    input  logic             cmd_b_rev,
    input  logic [CNT_W-1:0] duty_max,
    output logic             a_in1,
    output logic             a_in2,
    output logic             b_in1,
    output logic             b_in2,
    output logic             busy,
    output logic             fault,
    output logic [1:0]       dbg_state_a_o,
    output logic [1:0]       dbg_state_b_o
);

    localparam int DW = $clog2(DEAD_CYCLES + 1);

`ifdef MOTOR_BRAKE_EN
    localparam logic STOP_LVL = 1'b1;
`else
    localparam logic STOP_LVL = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DEAD = 2'd2} state_e;
    // Encoding matches {rev, fwd} so the raw request bits cast straight onto it.
    typedef enum logic [1:0] {CMD_STOP = 2'd0, CMD_FWD = 2'd1, CMD_REV = 2'd2, CMD_ILL = 2'd3} cmd_e;

    logic [CNT_W-1:0] pwm_q;
    state_e           state_q [2];
    cmd_e             dir_q   [2];
    logic [CNT_W-1:0] duty_q  [2];
    logic [CNT_W-1:0] duty_d  [2];
    logic [CNT_W:0]   sum     [2];
    logic [DW-1:0]    dead_q  [2];
    logic [1:0]       in1_q;
    logic [1:0]       in2_q;
    logic [1:0]       ill_q;
    logic             busy_q;
    logic             fault_q;
    cmd_e             cmd     [2];
    logic             wrap;

    assign cmd[0] = cmd_e'({cmd_a_rev, cmd_a_fwd});
    assign cmd[1] = cmd_e'({cmd_b_rev, cmd_b_fwd});
    assign wrap   = (pwm_q == {CNT_W{1'b1}});

    // One extra bit on the sum keeps the ramp from wrapping past the ceiling.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            sum[i]    = {1'b0, duty_q[i]} + (CNT_W + 1)'(RAMP_STEP);
            duty_d[i] = (sum[i] > {1'b0, duty_max}) ? duty_max : sum[i][CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_q   <= '0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
            in1_q   <= '0;
            in2_q   <= '0;
            ill_q   <= '0;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= IDLE;
                dir_q[i]   <= CMD_STOP;
                duty_q[i]  <= '0;
                dead_q[i]  <= '0;
            end
        end else begin
            pwm_q   <= pwm_q + 1'b1;
            busy_q  <= (state_q[0] == DEAD) || (state_q[1] == DEAD);
            fault_q <= fault_q | (|ill_q);
            for (int i = 0; i < 2; i++) begin
                ill_q[i] <= (cmd[i] == CMD_ILL);
                case (state_q[i])
                    IDLE: begin
                        in1_q[i] <= STOP_LVL;
                        in2_q[i] <= STOP_LVL;
                        if (cmd[i] == CMD_FWD || cmd[i] == CMD_REV) begin
                            state_q[i] <= RUN;
                            dir_q[i]   <= cmd[i];
                            duty_q[i]  <= '0;
                        end
                    end
                    RUN: begin
                        in1_q[i] <= (dir_q[i] == CMD_FWD) && (pwm_q < duty_q[i]);
                        in2_q[i] <= (dir_q[i] == CMD_REV) && (pwm_q < duty_q[i]);
                        if (cmd[i] != dir_q[i]) begin
                            state_q[i] <= DEAD;
                            dead_q[i]  <= DW'(DEAD_CYCLES - 1);
                        end else if (wrap) begin
                            duty_q[i] <= duty_d[i];
                        end
                    end
                    DEAD: begin
                        in1_q[i] <= 1'b0;
                        in2_q[i] <= 1'b0;
                        if (dead_q[i] == '0) begin
                            if (cmd[i] == CMD_FWD || cmd[i] == CMD_REV) begin
                                state_q[i] <= RUN;
                                dir_q[i]   <= cmd[i];
                                duty_q[i]  <= '0;
                            end else begin
                                state_q[i] <= IDLE;
                            end
                        end else begin
                            dead_q[i] <= dead_q[i] - 1'b1;
                        end
                    end
                    default: state_q[i] <= IDLE;
                endcase
            end
        end
    end

    assign a_in1         = in1_q[0];
    assign a_in2         = in2_q[0];
    assign b_in1         = in1_q[1];
    assign b_in2         = in2_q[1];
    assign busy          = busy_q;
    assign fault         = fault_q;
    assign dbg_state_a_o = state_q[0];
    assign dbg_state_b_o = state_q[1];

endmodule

// File: tb/tb_microbot_motor_driver.sv
// Self-checking bench for microbot_motor_driver (coast build): per-period ramp table,
// reversal dead time, illegal command fault, and reset during dead time.
module tb_microbot_motor_driver;

    localparam int CNT_W = 8;
    localparam int PER   = 256;
    localparam int DEADC = 16;
    localparam int W     = 45;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DEAD = 2'd2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_a_fwd = 1'b0, cmd_a_rev = 1'b0;
    logic             cmd_b_fwd = 1'b0, cmd_b_rev = 1'b0;
    logic [CNT_W-1:0] duty_max = 8'd255;
    logic             a_in1, a_in2, b_in1, b_in2, busy, fault;
    logic [1:0]       st_a, st_b;

    always #5 clk = ~clk;

    microbot_motor_driver #(.CNT_W(CNT_W), .DEAD_CYCLES(DEADC), .RAMP_STEP(32)) dut (
        .clk(clk), .reset(reset),
        .cmd_a_fwd(cmd_a_fwd), .cmd_a_rev(cmd_a_rev),
        .cmd_b_fwd(cmd_b_fwd), .cmd_b_rev(cmd_b_rev),
        .duty_max(duty_max),
        .a_in1(a_in1), .a_in2(a_in2), .b_in1(b_in1), .b_in2(b_in2),
        .busy(busy), .fault(fault),
        .dbg_state_a_o(st_a), .dbg_state_b_o(st_b)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int both_cnt = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [CNT_W-1:0] dm;
        int               a1;
    } vec_t;
    vec_t vecs[18];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if ((a_in1 && a_in2) || (b_in1 && b_in2)) both_cnt++;
    endtask

    function automatic logic [W-1:0] pack(input int a1, a2, b1, b2, bz);
        return {9'(a1), 9'(a2), 9'(b1), 9'(b2), 9'(bz)};
    endfunction

    task automatic run_window(input int n, output logic [W-1:0] act);
        int c1 = 0, c2 = 0, c3 = 0, c4 = 0, c5 = 0;
        for (int i = 0; i < n; i++) begin
            step();
            c1 += int'(a_in1); c2 += int'(a_in2);
            c3 += int'(b_in1); c4 += int'(b_in2);
            c5 += int'(busy);
        end
        act = pack(c1, c2, c3, c4, c5);
    endtask

    task automatic sb_check(input string name, input logic [W-1:0] act);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            n_tests++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s: got a1=%0d a2=%0d b1=%0d b2=%0d busy=%0d expected a1=%0d a2=%0d b1=%0d b2=%0d busy=%0d",
                         name, act[44:36], act[35:27], act[26:18], act[17:9], act[8:0],
                         e[44:36], e[35:27], e[26:18], e[17:9], e[8:0]);
            end
        end
    endtask

    initial begin
        logic [W-1:0] act;
        int ok;
        int a1_list[18] = '{0, 32, 64, 96, 128, 160, 192, 224, 64, 64, 64, 96, 128, 160, 192, 224, 255, 255};
        for (int p = 0; p < 18; p++) begin
            vecs[p].dm = (p >= 7 && p <= 9) ? 8'd64 : 8'd255;
            vecs[p].a1 = a1_list[p];
        end

        // Reset held three cycles, then released with all commands low.
        repeat (3) step();
        check("rst a_in1", a_in1, 0);
        check("rst a_in2", a_in2, 0);
        check("rst b_pins", {b_in1, b_in2}, 0);
        check("rst busy", busy, 0);
        check("rst fault", fault, 0);
        check("rst state_a", st_a, S_IDLE);
        check("rst state_b", st_b, S_IDLE);
        reset = 1'b0;
        ok = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if ({a_in1, a_in2, b_in1, b_in2, busy, fault} == 6'b0 && st_a == S_IDLE && st_b == S_IDLE) ok++;
        end
        check("idle after release", ok, 5);

        // Realign the PWM phase: window p covers samples 256p+1 .. 256p+256.
        reset = 1'b1;
        step();
        reset = 1'b0;
        cmd_a_fwd = 1'b1;
        cyc = 0;
        for (int p = 0; p < 18; p++) begin
            duty_max = vecs[p].dm;
            exp_q.push_back(pack(vecs[p].a1, 0, 0, 0, 0));
            run_window(PER, act);
            sb_check($sformatf("ramp window %0d", p), act);
        end

        // Reversal A fwd -> rev while at full duty.
        repeat (10) step();
        check("pre-rev a_in1 high", a_in1, 1);
        cmd_a_fwd = 1'b0;
        cmd_a_rev = 1'b1;
        step();
        check("rev edge a_in1", a_in1, 1);
        check("rev edge busy", busy, 0);
        ok = 0;
        for (int i = 0; i < DEADC; i++) begin
            step();
            if (!a_in1 && !a_in2 && busy) ok++;
        end
        check("rev dead cycles", ok, DEADC);
        step();
        check("rev after dead busy", busy, 0);
        check("rev after dead a_in2", a_in2, 0);
        check("rev state_a", st_a, S_RUN);
        exp_q.push_back(pack(0, 0, 0, 0, 0));
        run_window(19 * PER - cyc, act);
        sb_check("rev partial window", act);
        exp_q.push_back(pack(0, 32, 0, 0, 0));
        exp_q.push_back(pack(0, 64, 0, 0, 0));
        run_window(PER, act);
        sb_check("rev ramp window 1", act);
        run_window(PER, act);
        sb_check("rev ramp window 2", act);

        // Illegal command on B while it runs.
        cmd_b_fwd = 1'b1;
        repeat (40) step();
        check("b run", st_b, S_RUN);
        cmd_b_rev = 1'b1;
        step();
        check("ill edge fault", fault, 0);
        check("ill edge state_b", st_b, S_DEAD);
        cmd_b_fwd = 1'b0;
        cmd_b_rev = 1'b0;
        ok = 0;
        for (int i = 1; i <= DEADC; i++) begin
            step();
            if (fault && busy && !b_in1 && !b_in2 &&
                (st_b == ((i < DEADC) ? S_DEAD : S_IDLE))) ok++;
        end
        check("ill dead sequence", ok, DEADC);
        step();
        check("ill done busy", busy, 0);
        check("ill state_b idle", st_b, S_IDLE);
        repeat (20) step();
        check("fault sticky", fault, 1);
        check("a still run", st_a, S_RUN);

        // Reset in the middle of A's dead time.
        cmd_a_rev = 1'b0;
        cmd_a_fwd = 1'b1;
        step();
        check("mid-dead state_a", st_a, S_DEAD);
        repeat (4) step();
        check("mid-dead busy", busy, 1);
        reset = 1'b1;
        step();
        check("rst dead pins", {a_in1, a_in2, b_in1, b_in2}, 0);
        check("rst dead busy", busy, 0);
        check("rst dead fault", fault, 0);
        check("rst dead state_a", st_a, S_IDLE);
        reset = 1'b0;
        step();
        check("post rst fwd run", st_a, S_RUN);
        check("post rst fault", fault, 0);
        repeat (3) step();
        check("post rst busy", busy, 0);

        check("legs never both high", both_cnt, 0);
        check("scoreboard drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
